// File: rtl/fft_sample_deserializer.sv
// -----------------------------------------------------------------------------
// fft_sample_deserializer
//
// Serial-to-parallel front end for the FFT datapath. Samples arrive one per
// recv handshake and are written, in arrival order, into a registered frame
// buffer. Once N_SAMPLES samples are collected, the buffer is offered as one
// parallel frame on the send interface. It sustains one sample per cycle
// with no gap between frames.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   reset     : asynchronous active-low reset
//   recv_msg  : incoming serial sample
//   recv_val  : recv_msg valid
//   recv_rdy  : block accepts a sample this cycle (0 while reset is low)
//   send_msg  : assembled frame, element i = i-th sample of the frame
//   send_val  : frame valid (high exactly while the buffer is full)
//   send_rdy  : downstream accepts the frame
//
// state | meaning
// ------+------------------------------------------------------------
// FILL  | collecting samples; r_cnt is the next buffer slot to write
// FULL  | frame complete and offered downstream; r_cnt is 0
// -----------------------------------------------------------------------------
module fft_sample_deserializer #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] recv_msg,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0],
  output logic                 send_val,
  input  logic                 send_rdy
);

  localparam int CW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [BIT_WIDTH-1:0] r_buf [N_SAMPLES-1:0];

  logic                 w_recv_rdy;
  logic                 w_recv_fire;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_FILL: begin
        if (w_recv_fire) begin
          // N_SAMPLES is a power of two, so the increment wraps to 0 on
          // the last slot by itself.
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == LAST_IDX) begin
            w_state_nxt = S_FULL;
          end
        end
      end
      S_FULL: begin
        if (send_rdy) begin
          w_state_nxt = S_FILL;
          // A sample accepted alongside the departing frame lands in slot 0
          // (r_cnt is 0 here), so the new frame resumes at slot 1.
          w_cnt_nxt   = w_recv_fire ? CW'(1) : '0;
        end
      end
      default: begin
        w_state_nxt = S_FILL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_recv_rdy = 1'b0;
    send_val   = 1'b0;
    case (r_state)
      S_FILL: w_recv_rdy = 1'b1;
      S_FULL: begin
        // Pass-through lets a new frame start in the cycle the old one leaves.
        w_recv_rdy = send_rdy;
        send_val   = 1'b1;
      end
      default: begin
        w_recv_rdy = 1'b0;
        send_val   = 1'b0;
      end
    endcase
  end

  // Ready is gated by reset directly so it drops without waiting for a clock.
  assign recv_rdy    = w_recv_rdy & reset;
  assign w_recv_fire = recv_val & recv_rdy;

  // ---------------------------------------------------------------------------
  // Frame buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_recv_fire) begin
      r_buf[r_cnt] <= recv_msg;
    end
  end

  always_comb begin
    for (int i = 0; i < N_SAMPLES; i++) begin
      send_msg[i] = r_buf[i];
    end
  end

endmodule

// File: tb/tb_fft_sample_deserializer.sv
module tb_fft_sample_deserializer;

  localparam int N  = 8;
  localparam int BW = 32;

  logic          clk;
  logic          reset;

  logic [BW-1:0] recv_msg;
  logic          recv_val;
  logic          recv_rdy;
  logic [BW-1:0] send_msg [N-1:0];
  logic          send_val;
  logic          send_rdy;

  logic [15:0]   recv_msg2;
  logic          recv_val2;
  logic          recv_rdy2;
  logic [15:0]   send_msg2 [1:0];
  logic          send_val2;
  logic          send_rdy2;

  fft_sample_deserializer #(.BIT_WIDTH(BW), .N_SAMPLES(N)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .send_msg (send_msg),
    .send_val (send_val),
    .send_rdy (send_rdy)
  );

  fft_sample_deserializer #(.BIT_WIDTH(16), .N_SAMPLES(2)) u_dut2 (
    .clk      (clk),
    .reset    (reset),
    .recv_msg (recv_msg2),
    .recv_val (recv_val2),
    .recv_rdy (recv_rdy2),
    .send_msg (send_msg2),
    .send_val (send_val2),
    .send_rdy (send_rdy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [N*BW-1:0] frame_t;

  int     n_checks;
  int     n_fail;
  frame_t exp_q [$];
  frame_t m_frame;
  int     m_cnt;
  logic   m_full;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One cycle: apply inputs, check at the falling edge against the model,
  // then advance the model across the rising edge.
  task automatic drive(input logic v, input logic [31:0] m, input logic s);
    logic   rdy_m;
    frame_t cur;
    recv_val = v;
    recv_msg = m;
    send_rdy = s;
    @(negedge clk);
    rdy_m = !m_full || s;
    check("send_val", 32'(send_val), 32'(m_full));
    check("recv_rdy", 32'(recv_rdy), 32'(rdy_m));
    if (m_full) begin
      check("frame_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        cur = exp_q[0];
        for (int i = 0; i < N; i++) begin
          check($sformatf("send_msg[%0d]", i), send_msg[i], cur[i*BW +: BW]);
        end
        if (s) void'(exp_q.pop_front());
      end
    end
    @(posedge clk);
    if (m_full && s) m_full = 1'b0;
    if (v && rdy_m) begin
      m_frame[m_cnt*BW +: BW] = m;
      m_cnt++;
      if (m_cnt == N) begin
        exp_q.push_back(m_frame);
        m_full = 1'b1;
        m_cnt  = 0;
      end
    end
    #1;
  endtask

  // Called just after a rising edge: reset is dropped between edges and
  // its effect must be visible before the next edge.
  task automatic async_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_send_val", 32'(send_val), 32'd0);
    check("rst_recv_rdy", 32'(recv_rdy), 32'd0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_buf[%0d]", i), send_msg[i], 32'd0);
    end
    check("rst_recv_rdy2", 32'(recv_rdy2), 32'd0);
    m_full  = 1'b0;
    m_cnt   = 0;
    m_frame = '0;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    m_full    = 1'b0;
    m_cnt     = 0;
    m_frame   = '0;
    reset     = 1'b0;
    recv_val  = 1'b0;
    recv_msg  = '0;
    send_rdy  = 1'b0;
    recv_val2 = 1'b0;
    recv_msg2 = '0;
    send_rdy2 = 1'b0;

    #1;
    check("init_send_val", 32'(send_val), 32'd0);
    check("init_recv_rdy", 32'(recv_rdy), 32'd0);
    check("init_buf0", send_msg[0], 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Basic fill with downstream stalled, then backpressure hold
    for (int i = 1; i <= 8; i++) drive(1'b1, 32'(i), 1'b0);
    repeat (2) drive(1'b0, 32'd0, 1'b0);
    repeat (5) drive(1'b1, 32'hDEAD, 1'b0);
    // Frame leaves and 0xDEAD enters slot 0 in the same cycle
    drive(1'b1, 32'hDEAD, 1'b1);
    for (int i = 1; i <= 7; i++) drive(1'b1, 32'hA0 + 32'(i), 1'b1);

    // Continuous streaming, no bubbles
    for (int i = 0; i < 24; i++) drive(1'b1, 32'(i), 1'b1);
    repeat (2) drive(1'b0, 32'd0, 1'b1);

    // Gapped input: valid toggles every cycle
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'(i) << 16, 1'b0);
      drive(1'b0, 32'hBAD0, 1'b0);
    end
    drive(1'b0, 32'd0, 1'b1);
    drive(1'b0, 32'd0, 1'b0);

    // Reset in the middle of a partial frame
    for (int i = 0; i < 5; i++) drive(1'b1, 32'd50 + 32'(i), 1'b0);
    async_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 32'd100 + 32'(i), 1'b0);
    drive(1'b0, 32'd0, 1'b0);
    drive(1'b0, 32'd0, 1'b1);
    drive(1'b0, 32'd0, 1'b0);
    check("frames_drained", 32'(exp_q.size()), 32'd0);

    // Two-sample, 16-bit instance
    recv_val2 = 1'b1;
    recv_msg2 = 16'hFFFF;
    send_rdy2 = 1'b0;
    @(negedge clk);
    check("n2_rdy_first", 32'(recv_rdy2), 32'd1);
    @(posedge clk);
    #1 recv_msg2 = 16'h8000;
    @(negedge clk);
    check("n2_val_early", 32'(send_val2), 32'd0);
    check("n2_rdy_second", 32'(recv_rdy2), 32'd1);
    @(posedge clk);
    #1 recv_val2 = 1'b0;
    @(negedge clk);
    check("n2_val", 32'(send_val2), 32'd1);
    check("n2_msg0", 32'(send_msg2[0]), 32'h0000FFFF);
    check("n2_msg1", 32'(send_msg2[1]), 32'h00008000);
    check("n2_rdy_full", 32'(recv_rdy2), 32'd0);
    @(posedge clk);
    #1 send_rdy2 = 1'b1;
    @(negedge clk);
    check("n2_rdy_pass", 32'(recv_rdy2), 32'd1);
    @(posedge clk);
    #1 send_rdy2 = 1'b0;
    @(negedge clk);
    check("n2_val_after", 32'(send_val2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
